// File: rtl/qoi_dma_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qoi_types : shared types and constants for the QOI DMA sequencer    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package qoi_types;

   typedef enum logic [2:0] {
      DMA_IDLE    = 3'd0,
      DMA_REQ     = 3'd1,
      DMA_GRANT   = 3'd2,
      DMA_READ    = 3'd3,
      DMA_WRITE   = 3'd4,
      DMA_RELEASE = 3'd5,
      DMA_PAUSE   = 3'd6
   } dma_state_t;

   localparam logic [2:0] DMA_SRC_LO = 3'd0;
   localparam logic [2:0] DMA_SRC_HI = 3'd1;
   localparam logic [2:0] DMA_DST_LO = 3'd2;
   localparam logic [2:0] DMA_DST_HI = 3'd3;
   localparam logic [2:0] DMA_LEN_LO = 3'd4;
   localparam logic [2:0] DMA_LEN_HI = 3'd5;
   localparam logic [2:0] DMA_CTRL   = 3'd6;
   localparam logic [2:0] DMA_STATUS = 3'd7;

   localparam int CTRL_START     = 0;
   localparam int CTRL_IRQ_EN    = 1;
   localparam int CTRL_DST_FIXED = 2;
   localparam int CTRL_ABORT     = 3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   localparam logic [15:0] DMA_BASE_ADDR = 16'hA408;

endpackage
`default_nettype wire

// File: rtl/qoi_dma_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qoi_dma_ctrl_if : CPU register port and shared system bus signals   |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
interface qoi_dma_ctrl_if;
   logic        cs;
   logic        we;
   logic [2:0]  addr;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        cpu_we;
   logic        rdy;
   logic        bus_sel;
   logic [15:0] bus_ab;
   logic        bus_we;
   logic [7:0]  bus_do;
   logic [7:0]  bus_di;

   // master: the DMA engine, which owns the bus during a tenure
   modport master (
      input  cs, we, addr, data_i, cpu_we, bus_di,
      output data_o, rdy, bus_sel, bus_ab, bus_we, bus_do
   );

   modport slave (
      output cs, we, addr, data_i, cpu_we, bus_di,
      input  data_o, rdy, bus_sel, bus_ab, bus_we, bus_do
   );
endinterface
`default_nettype wire

// File: rtl/qoi_dma_ctrl_regs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qoi_dma_regs : register file, live counters and CTRL/STATUS logic   |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module qoi_dma_regs
   import qoi_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   input  logic        busy,
   input  logic        step,
   input  logic        done_set,
   input  logic        err_set,
   output logic [15:0] src,
   output logic [15:0] dst,
   output logic [15:0] len,
   output logic        start,
   output logic        abort,
   output logic        irq
);

   logic r_irq_en;
   logic r_dst_fixed;
   logic r_done;
   logic r_err;
   logic r_zero_pend;
   logic w_wr;
   logic w_ctrl_wr;
   logic w_stat_wr;

   assign w_wr      = cs & we;
   assign w_ctrl_wr = w_wr && (addr == DMA_CTRL);
   assign w_stat_wr = w_wr && (addr == DMA_STATUS);
   assign start     = w_ctrl_wr & data_i[CTRL_START];
   assign abort     = w_ctrl_wr & data_i[CTRL_ABORT];
   assign irq       = r_done & r_irq_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src         <= 16'h0000;
         dst         <= 16'h0000;
         len         <= 16'h0000;
         r_irq_en    <= 1'b0;
         r_dst_fixed <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_zero_pend <= 1'b0;
      end else begin
         r_zero_pend <= 1'b0;
         if (w_wr && !busy) begin
            case (addr)
               DMA_SRC_LO: src[7:0]  <= data_i;
               DMA_SRC_HI: src[15:8] <= data_i;
               DMA_DST_LO: dst[7:0]  <= data_i;
               DMA_DST_HI: dst[15:8] <= data_i;
               DMA_LEN_LO: len[7:0]  <= data_i;
               DMA_LEN_HI: len[15:8] <= data_i;
               default: ;
            endcase
         end else if (step) begin
            src <= src + 16'd1;
            if (!r_dst_fixed) dst <= dst + 16'd1;
            len <= len - 16'd1;
         end
         if (w_ctrl_wr) begin
            r_irq_en    <= data_i[CTRL_IRQ_EN];
            r_dst_fixed <= data_i[CTRL_DST_FIXED];
         end
         if (w_stat_wr) begin
            if (data_i[STAT_DONE]) r_done <= 1'b0;
            if (data_i[STAT_ERR])  r_err  <= 1'b0;
         end
         // Zero-length start: flag the error now, report completion a cycle later
         if (start && !busy && (len == 16'd0)) begin
            r_err       <= 1'b1;
            r_zero_pend <= 1'b1;
         end
         if (r_zero_pend || done_set) r_done <= 1'b1;
         if (err_set)                 r_err  <= 1'b1;
      end
   end

   always_comb begin
      data_o = 8'h00;
      case (addr)
         DMA_SRC_LO: data_o = src[7:0];
         DMA_SRC_HI: data_o = src[15:8];
         DMA_DST_LO: data_o = dst[7:0];
         DMA_DST_HI: data_o = dst[15:8];
         DMA_LEN_LO: data_o = len[7:0];
         DMA_LEN_HI: data_o = len[15:8];
         DMA_CTRL: begin
            data_o[CTRL_IRQ_EN]    = r_irq_en;
            data_o[CTRL_DST_FIXED] = r_dst_fixed;
         end
         DMA_STATUS: begin
            data_o[STAT_BUSY] = busy;
            data_o[STAT_DONE] = r_done;
            data_o[STAT_ERR]  = r_err;
         end
         default: data_o = 8'h00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/qoi_dma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qoi_dma_ctrl : DMA sequencer and bus arbiter for the 65C02 bus      |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module qoi_dma_ctrl
   import qoi_types::*;
#(
   parameter int BURST = 16,
   parameter int GAP   = 4
) (
   input  logic           clk,
   input  logic           rst,
   qoi_dma_ctrl_if.master bus,
   output logic           irq
);

   localparam int C_BURST_W = $clog2(BURST + 1);
   localparam int C_GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;

   dma_state_t             r_state;
   logic                   r_rdy;
   logic                   r_sel;
   logic                   r_we;
   logic                   r_finish;
   logic                   r_abort;
   logic [C_BURST_W-1:0]   r_burst;
   logic [C_GAP_W-1:0]     r_gap;

   logic [15:0] w_src;
   logic [15:0] w_dst;
   logic [15:0] w_len;
   logic        w_start;
   logic        w_abort;
   logic        w_abort_now;
   logic        w_busy;
   logic        w_step;
   logic        w_rel_end;
   logic        w_done_set;
   logic        w_err_set;

   assign w_busy      = (r_state != DMA_IDLE);
   assign w_step      = (r_state == DMA_WRITE);
   assign w_abort_now = w_abort | r_abort;
   assign w_rel_end   = (r_state == DMA_RELEASE) && (r_finish || w_abort_now);
   assign w_done_set  = w_rel_end;
   assign w_err_set   = w_rel_end && w_abort_now;

   qoi_dma_regs u_regs (
      .clk      (clk),
      .rst      (rst),
      .cs       (bus.cs),
      .we       (bus.we),
      .addr     (bus.addr),
      .data_i   (bus.data_i),
      .data_o   (bus.data_o),
      .busy     (w_busy),
      .step     (w_step),
      .done_set (w_done_set),
      .err_set  (w_err_set),
      .src      (w_src),
      .dst      (w_dst),
      .len      (w_len),
      .start    (w_start),
      .abort    (w_abort),
      .irq      (irq)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= DMA_IDLE;
         r_rdy    <= 1'b1;
         r_sel    <= 1'b0;
         r_we     <= 1'b0;
         r_finish <= 1'b0;
         r_abort  <= 1'b0;
         r_burst  <= '0;
         r_gap    <= '0;
      end else begin
         if (w_abort && w_busy) r_abort <= 1'b1;
         case (r_state)
            DMA_IDLE: begin
               if (w_start && (w_len != 16'd0)) begin
                  r_state  <= DMA_REQ;
                  r_finish <= 1'b0;
               end
            end
            DMA_REQ: begin
               if (w_abort_now) begin
                  r_state <= DMA_RELEASE;
               end else if (!bus.cpu_we) begin
                  r_state <= DMA_GRANT;
                  r_rdy   <= 1'b0;
                  r_sel   <= 1'b1;
                  r_burst <= '0;
               end
            end
            DMA_GRANT: begin
               if (w_abort_now) begin
                  r_state <= DMA_RELEASE;
                  r_rdy   <= 1'b1;
                  r_sel   <= 1'b0;
               end else begin
                  r_state <= DMA_READ;
               end
            end
            DMA_READ: begin
               r_state <= DMA_WRITE;
               r_we    <= 1'b1;
            end
            DMA_WRITE: begin
               r_we    <= 1'b0;
               r_burst <= r_burst + C_BURST_W'(1);
               if (w_len == 16'd1) begin
                  r_state  <= DMA_RELEASE;
                  r_finish <= 1'b1;
                  r_rdy    <= 1'b1;
                  r_sel    <= 1'b0;
               end else if (w_abort_now || (r_burst == C_BURST_W'(BURST - 1))) begin
                  r_state <= DMA_RELEASE;
                  r_rdy   <= 1'b1;
                  r_sel   <= 1'b0;
               end else begin
                  r_state <= DMA_READ;
               end
            end
            DMA_RELEASE: begin
               if (r_finish || w_abort_now) begin
                  r_state  <= DMA_IDLE;
                  r_finish <= 1'b0;
                  r_abort  <= 1'b0;
               end else if (GAP <= 1) begin
                  r_state <= DMA_REQ;
               end else begin
                  // The RELEASE cycle is the first of the GAP cycles the CPU keeps
                  r_state <= DMA_PAUSE;
                  r_gap   <= C_GAP_W'(1);
               end
            end
            DMA_PAUSE: begin
               if (w_abort_now) begin
                  r_state <= DMA_RELEASE;
               end else if (r_gap == C_GAP_W'(GAP - 1)) begin
                  r_state <= DMA_REQ;
               end else begin
                  r_gap <= r_gap + C_GAP_W'(1);
               end
            end
            default: begin
               r_state <= DMA_IDLE;
               r_rdy   <= 1'b1;
               r_sel   <= 1'b0;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.bus_ab = 16'h0000;
      case (r_state)
         DMA_READ:  bus.bus_ab = w_src;
         DMA_WRITE: bus.bus_ab = w_dst;
         default:   bus.bus_ab = 16'h0000;
      endcase
   end

   // Memories are registered, so read data arrives during WRITE and is forwarded straight out
   assign bus.bus_do  = (r_state == DMA_WRITE) ? bus.bus_di : 8'h00;
   assign bus.rdy     = r_rdy;
   assign bus.bus_sel = r_sel;
   assign bus.bus_we  = r_we;

endmodule
`default_nettype wire

// File: tb/tb_qoi_dma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qoi_dma_ctrl : self-checking bench with a behavioural copy model |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_qoi_dma_ctrl;
   import qoi_types::*;

   localparam int BURST = 16;
   localparam int GAP   = 4;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic irq;
   logic fill_req = 1'b0;
   bit   rec      = 1'b0;

   int n_pass  = 0;
   int n_tot   = 0;
   int n_fail  = 0;
   int inv_bad = 0;
   int rdy_low = 0;

   logic [7:0]  mem [0:65535];
   logic [23:0] wlog [$];
   bit          rdy_q [$];
   logic [7:0]  src_q [$];

   always #5 clk = ~clk;

   qoi_dma_ctrl_if bif ();

   qoi_dma_ctrl #(.BURST(BURST), .GAP(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.master),
      .irq (irq)
   );

   // System memory with registered read, plus bus monitor
   always @(posedge clk) begin
      if (fill_req)
         for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
      else if (bif.bus_sel && bif.bus_we)
         mem[bif.bus_ab] <= bif.bus_do;
      bif.bus_di <= mem[bif.bus_ab];
      if (!bif.rdy) rdy_low++;
      if (rec) rdy_q.push_back(bif.rdy);
      if (bif.bus_we) wlog.push_back({bif.bus_ab, bif.bus_do});
      if (bif.bus_sel !== ~bif.rdy) inv_bad++;
      if (bif.bus_we && !bif.bus_sel) inv_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
      bif.cs = 1'b1; bif.we = 1'b1; bif.addr = a; bif.data_i = d;
      tick();
      bif.cs = 1'b0; bif.we = 1'b0;
   endtask

   task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
      bif.addr = a;
      #1;
      d = bif.data_o;
   endtask

   task automatic read16(input logic [2:0] lo, output logic [15:0] v);
      logic [7:0] l, h;
      reg_rd(lo, l);
      reg_rd(lo + 3'd1, h);
      v = {h, l};
   endtask

   task automatic set_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      reg_wr(DMA_SRC_LO, s[7:0]);
      reg_wr(DMA_SRC_HI, s[15:8]);
      reg_wr(DMA_DST_LO, d[7:0]);
      reg_wr(DMA_DST_HI, d[15:8]);
      reg_wr(DMA_LEN_LO, n[7:0]);
      reg_wr(DMA_LEN_HI, n[15:8]);
   endtask

   task automatic snap(input logic [15:0] s, input int n);
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(mem[16'(s + i)]);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic [7:0] st;
      int n = 0;
      reg_rd(DMA_STATUS, st);
      while (st[STAT_BUSY] && n < budget) begin
         tick();
         reg_rd(DMA_STATUS, st);
         n++;
      end
      chk(tag, 32'(st[STAT_BUSY]), 0);
   endtask

   task automatic wait_log(input string tag, input int target, input int budget);
      int n = 0;
      while (wlog.size() < target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(wlog.size() >= target), 1);
   endtask

   // Expected bus writes: byte i of the source block lands at dst+i (or dst if fixed)
   task automatic check_writes(input string tag, input int base, input logic [15:0] d,
                               input bit fixed, input int n);
      int bad = 0;
      logic [23:0] e;
      chk({tag, "_count"}, wlog.size() - base, n);
      for (int i = 0; i < n; i++) begin
         e = {16'(d + (fixed ? 0 : i)), src_q[i]};
         if (base + i >= wlog.size()) bad++;
         else if (wlog[base + i] !== e) bad++;
      end
      chk({tag, "_data"}, bad, 0);
   endtask

   initial begin
      logic [7:0]  rd;
      logic [15:0] v16, s, d;
      int base, rl0, r0, rem, k, bad, n;
      int lows [$];
      int highs [$];
      int exp_lows [$];
      int cur_lo, cur_hi;
      bit seen_lo;

      bif.cs = 1'b0; bif.we = 1'b0; bif.addr = 3'd0; bif.data_i = 8'h00; bif.cpu_we = 1'b0;
      #1 rst = 1'b0;
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      tick();

      chk("rst_rdy", bif.rdy, 1);
      chk("rst_bus_sel", bif.bus_sel, 0);
      chk("rst_bus_we", bif.bus_we, 0);
      chk("rst_bus_ab", bif.bus_ab, 0);
      chk("rst_bus_do", bif.bus_do, 0);
      chk("rst_irq", irq, 0);
      for (int a = 0; a < 8; a++) begin
         reg_rd(3'(a), rd);
         chk("rst_reg", rd, 0);
      end
      @(negedge clk) rst = 1'b1;
      tick();

      // Basic 3-byte copy into the accelerator window
      s = 16'h8000; d = 16'hA000;
      set_xfer(s, d, 16'd3);
      snap(s, 3);
      base = wlog.size(); rl0 = rdy_low;
      reg_wr(DMA_CTRL, 8'h01);
      wait_idle("t1_idle", 200);
      chk("t1_rdy_low_cycles", rdy_low - rl0, 7);
      check_writes("t1_wr", base, d, 1'b0, 3);
      reg_rd(DMA_STATUS, rd); chk("t1_status", rd, 8'h02);
      chk("t1_irq_masked", irq, 0);
      read16(DMA_LEN_LO, v16); chk("t1_len", v16, 16'h0000);
      read16(DMA_SRC_LO, v16); chk("t1_src", v16, 16'h8003);
      read16(DMA_DST_LO, v16); chk("t1_dst", v16, 16'hA003);
      reg_wr(DMA_STATUS, 8'h06);

      // 40 bytes: split into tenures of at most BURST bytes with GAP+1 high cycles between
      s = 16'h8000 + 16'($urandom_range(0, 16'h0F00));
      d = 16'hA000 + 16'($urandom_range(0, 16'h03C0));
      set_xfer(s, d, 16'd40);
      snap(s, 40);
      base = wlog.size();
      rec = 1'b1; r0 = rdy_q.size();
      reg_wr(DMA_CTRL, 8'h03);
      wait_idle("t2_idle", 500);
      rec = 1'b0;
      cur_lo = 0; cur_hi = 0; seen_lo = 1'b0;
      for (int i = r0; i < rdy_q.size(); i++) begin
         if (!rdy_q[i]) begin
            if (seen_lo && cur_hi > 0) highs.push_back(cur_hi);
            cur_hi = 0; cur_lo++; seen_lo = 1'b1;
         end else begin
            if (cur_lo > 0) lows.push_back(cur_lo);
            cur_lo = 0;
            if (seen_lo) cur_hi++;
         end
      end
      rem = 40;
      while (rem > 0) begin
         k = (rem < BURST) ? rem : BURST;
         exp_lows.push_back(1 + 2 * k);
         rem -= k;
      end
      chk("t2_tenures", lows.size(), exp_lows.size());
      chk("t2_gaps", highs.size(), exp_lows.size() - 1);
      for (int i = 0; i < lows.size() && i < exp_lows.size(); i++) chk("t2_tenure_len", lows[i], exp_lows[i]);
      for (int i = 0; i < highs.size(); i++) chk("t2_gap_len", highs[i], GAP + 1);
      check_writes("t2_wr", base, d, 1'b0, 40);
      bad = 0;
      for (int i = 0; i < 40; i++) if (mem[16'(d + i)] !== src_q[i]) bad++;
      chk("t2_mem", bad, 0);
      read16(DMA_SRC_LO, v16); chk("t2_src", v16, 16'(s + 40));
      chk("t2_irq", irq, 1);
      reg_wr(DMA_STATUS, 8'h02);
      chk("t2_irq_clr", irq, 0);
      reg_rd(DMA_STATUS, rd); chk("t2_status_clr", rd, 8'h00);

      // Source address wraps past 0xFFFF
      s = 16'hFFFE; d = 16'hA100;
      set_xfer(s, d, 16'd4);
      snap(s, 4);
      base = wlog.size();
      reg_wr(DMA_CTRL, 8'h01);
      wait_idle("t3_idle", 200);
      check_writes("t3_wr", base, d, 1'b0, 4);
      read16(DMA_SRC_LO, v16); chk("t3_src_wrap", v16, 16'h0002);
      reg_wr(DMA_STATUS, 8'h06);

      // A CPU write in progress holds off the bus grant
      s = 16'h8000 + 16'($urandom_range(0, 16'h0F00));
      d = 16'hA200;
      set_xfer(s, d, 16'd2);
      snap(s, 2);
      base = wlog.size();
      bif.cpu_we = 1'b1;
      reg_wr(DMA_CTRL, 8'h01);
      chk("t4_rdy_hold", bif.rdy, 1);
      chk("t4_sel_hold", bif.bus_sel, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_rdy_hold", bif.rdy, 1);
         chk("t4_sel_hold", bif.bus_sel, 0);
      end
      bif.cpu_we = 1'b0;
      tick();
      chk("t4_rdy_grant", bif.rdy, 0);
      wait_idle("t4_idle", 200);
      check_writes("t4_wr", base, d, 1'b0, 2);
      reg_wr(DMA_STATUS, 8'h06);

      // Zero length: ERR now, DONE one cycle later, no bus activity
      set_xfer(16'h8000, 16'hA000, 16'd0);
      base = wlog.size(); rl0 = rdy_low;
      reg_wr(DMA_CTRL, 8'h01);
      reg_rd(DMA_STATUS, rd); chk("t5_status_err", rd, 8'h04);
      tick();
      reg_rd(DMA_STATUS, rd); chk("t5_status", rd, 8'h06);
      tick(); tick();
      chk("t5_no_writes", wlog.size() - base, 0);
      chk("t5_no_stall", rdy_low - rl0, 0);
      reg_wr(DMA_STATUS, 8'h06);
      reg_rd(DMA_STATUS, rd); chk("t5_w1c", rd, 8'h00);

      // Fixed destination
      s = 16'h8000 + 16'($urandom_range(0, 16'h0F00));
      d = 16'hA400;
      set_xfer(s, d, 16'd4);
      snap(s, 4);
      base = wlog.size();
      reg_wr(DMA_CTRL, 8'h05);
      wait_idle("t6_idle", 200);
      check_writes("t6_wr", base, d, 1'b1, 4);
      read16(DMA_DST_LO, v16); chk("t6_dst", v16, 16'hA400);
      reg_wr(DMA_STATUS, 8'h06);
      reg_wr(DMA_CTRL, 8'h00);

      // Abort while the third byte is being read: that byte still completes
      s = 16'h8000 + 16'($urandom_range(0, 16'h0F00));
      d = 16'hA000 + 16'($urandom_range(0, 16'h0300));
      set_xfer(s, d, 16'd10);
      snap(s, 10);
      base = wlog.size();
      reg_wr(DMA_CTRL, 8'h01);
      wait_log("t7_reach", base + 2, 200);
      reg_wr(DMA_CTRL, 8'h08);
      wait_idle("t7_idle", 200);
      reg_rd(DMA_STATUS, rd); chk("t7_status", rd, 8'h06);
      read16(DMA_LEN_LO, v16); chk("t7_len", v16, 16'd7);
      read16(DMA_SRC_LO, v16); chk("t7_src", v16, 16'(s + 3));
      chk("t7_rdy", bif.rdy, 1);
      check_writes("t7_wr", base, d, 1'b0, 3);
      reg_wr(DMA_STATUS, 8'h06);

      // Asynchronous reset in the middle of a READ
      s = 16'h8000 + 16'($urandom_range(0, 16'h0F00));
      set_xfer(s, 16'hA000, 16'd10);
      base = wlog.size();
      reg_wr(DMA_CTRL, 8'h03);
      wait_log("t8_reach", base + 1, 200);
      n = 0;
      while (!(bif.bus_sel && !bif.bus_we) && n < 20) begin
         tick();
         n++;
      end
      chk("t8_in_read", 32'(bif.bus_sel && !bif.bus_we), 1);
      #2 rst = 1'b0;
      #1;
      chk("t8_rdy_async", bif.rdy, 1);
      chk("t8_sel_async", bif.bus_sel, 0);
      chk("t8_we_async", bif.bus_we, 0);
      chk("t8_ab_async", bif.bus_ab, 0);
      chk("t8_irq_async", irq, 0);
      bad = 0;
      for (int a = 0; a < 8; a++) begin
         reg_rd(3'(a), rd);
         if (rd !== 8'h00) bad++;
      end
      chk("t8_regs_zero", bad, 0);
      @(negedge clk) rst = 1'b1;
      tick(); tick();
      chk("t8_rdy_after", bif.rdy, 1);
      reg_rd(DMA_STATUS, rd); chk("t8_status_after", rd, 8'h00);

      chk("bus_invariants", inv_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
